// File: rtl/ps2_read_if.sv
// ps2_read_if - control/status bundle between the PS/2 frame reader and
// the PS/2 communication controller.
//   clk_main_loop : sample-rate square wave, rising transition = one sample tick
//   enable        : permits frame reception
//   reading       : a frame is being received
//   data[10:0]    : last complete raw frame, data[10] = start bit
//   done          : frame-complete level flag
//   err / errcode : error level flag and code (1 = timeout)
// master = controller side, slave = reader side.
interface ps2_read_if;
    logic        clk_main_loop;
    logic        enable;
    logic        reading;
    logic [10:0] data;
    logic        done;
    logic        err;
    logic [7:0]  errcode;

    modport master (
        output clk_main_loop, enable,
        input  reading, data, done, err, errcode
    );

    modport slave (
        input  clk_main_loop, enable,
        output reading, data, done, err, errcode
    );
endinterface

// File: rtl/ps2_read.sv
// ps2_read - receive-only PS/2 device-to-host frame reader.
// Samples the synchronised PS2C/PS2D lines once per sample tick, shifts in
// the 11 bits of a frame on PS2C falling edges and hands the raw frame to
// the controller. Framing and parity are not checked here.
// Ports:
//   qzt_clk : system clock (all state on its rising edge)
//   reset   : synchronous, active-high
//   bus     : ps2_read_if.slave (tick source, enable, frame/status outputs)
//   PS2C    : PS/2 clock line, observed only (never driven)
//   PS2D    : PS/2 data line, observed only (never driven)
module ps2_read #(
    parameter logic [7:0] TIMEOUT_TICKS = 8'd100
) (
    input  logic     qzt_clk,
    input  logic     reset,
    ps2_read_if.slave bus,
    inout  wire      PS2C,
    inout  wire      PS2D
);

    typedef enum logic {IDLE, RECV} state_t;

    // The send path owns these lines when it drives them.
    assign PS2C = 1'bz;
    assign PS2D = 1'bz;

    state_t      state_q, state_d;
    logic        c_s1_q, c_s1_d, c_s2_q, c_s2_d;
    logic        d_s1_q, d_s1_d, d_s2_q, d_s2_d;
    logic        cml_q, cml_d;
    logic        c_prev_q, c_prev_d;
    logic [10:0] shift_q, shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        reading_q, reading_d;
    logic [10:0] data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  errcode_q, errcode_d;

    logic        tick;
    logic        fall;
    logic [10:0] shift_nxt;
    logic [7:0]  to_cnt_nxt;

    always_comb begin
        c_s1_d = PS2C;
        c_s2_d = c_s1_q;
        d_s1_d = PS2D;
        d_s2_d = d_s1_q;
        cml_d  = bus.clk_main_loop;

        tick       = bus.clk_main_loop & ~cml_q;
        // Edge detection only happens at ticks, so glitches between ticks
        // and edges faster than the sample rate are filtered out.
        fall       = tick & c_prev_q & ~c_s2_q;
        shift_nxt  = {shift_q[9:0], d_s2_q};
        to_cnt_nxt = to_cnt_q + 8'd1;

        c_prev_d  = tick ? c_s2_q : c_prev_q;
        state_d   = state_q;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        to_cnt_d  = to_cnt_q;
        reading_d = reading_q;
        data_d    = data_q;
        done_d    = done_q;
        err_d     = err_q;
        errcode_d = errcode_q;

        case (state_q)
            IDLE: begin
                if (bus.enable && fall) begin
                    shift_d   = {10'b0, d_s2_q};
                    bitcnt_d  = 4'd1;
                    to_cnt_d  = 8'd0;
                    reading_d = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    errcode_d = 8'd0;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (!bus.enable) begin
                    // Abort silently; a partial frame is never resumed.
                    reading_d = 1'b0;
                    state_d   = IDLE;
                end else if (fall) begin
                    // Edge beats a coincident timeout.
                    shift_d  = shift_nxt;
                    bitcnt_d = bitcnt_q + 4'd1;
                    to_cnt_d = 8'd0;
                    if (bitcnt_q == 4'd10) begin
                        data_d    = shift_nxt;
                        done_d    = 1'b1;
                        reading_d = 1'b0;
                        state_d   = IDLE;
                    end
                end else if (tick) begin
                    to_cnt_d = to_cnt_nxt;
                    if (to_cnt_nxt == TIMEOUT_TICKS) begin
                        err_d     = 1'b1;
                        errcode_d = 8'd1;
                        reading_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            c_s1_q    <= 1'b1;
            c_s2_q    <= 1'b1;
            d_s1_q    <= 1'b1;
            d_s2_q    <= 1'b1;
            cml_q     <= 1'b0;
            c_prev_q  <= 1'b1;
            shift_q   <= 11'd0;
            bitcnt_q  <= 4'd0;
            to_cnt_q  <= 8'd0;
            reading_q <= 1'b0;
            data_q    <= 11'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            c_s1_q    <= c_s1_d;
            c_s2_q    <= c_s2_d;
            d_s1_q    <= d_s1_d;
            d_s2_q    <= d_s2_d;
            cml_q     <= cml_d;
            c_prev_q  <= c_prev_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            to_cnt_q  <= to_cnt_d;
            reading_q <= reading_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
        end
    end

    assign bus.reading = reading_q;
    assign bus.data    = data_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.errcode = errcode_q;

endmodule

// File: tb/tb_ps2_read.sv
module tb_ps2_read;

    localparam int HALF = 8;   // sample ticks per PS2C half period

    logic qzt_clk = 1'b0;
    logic reset   = 1'b1;
    logic c_drv   = 1'b1;
    logic d_drv   = 1'b1;
    wire  ps2c, ps2d;

    int nvec = 0;
    int nerr = 0;
    logic snap_rd, snap_done;

    ps2_read_if bus ();

    assign ps2c = c_drv;
    assign ps2d = d_drv;

    ps2_read dut (
        .qzt_clk (qzt_clk),
        .reset   (reset),
        .bus     (bus),
        .PS2C    (ps2c),
        .PS2D    (ps2d)
    );

    always #5 qzt_clk = ~qzt_clk;

    // Sample-rate square wave: toggles every 5 qzt_clk cycles.
    initial begin
        bus.clk_main_loop = 1'b0;
        forever begin
            repeat (5) @(posedge qzt_clk);
            #1 bus.clk_main_loop = ~bus.clk_main_loop;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge bus.clk_main_loop);
    endtask

    // Frame bits in line order: start, d0..d7, parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b0, b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], p, 1'b1};
    endfunction

    // Sends the first n bits; snapshots reading/done after bit index snap_at.
    task automatic send_bits(input logic [10:0] f, input int n, input int snap_at);
        for (int i = 0; i < n; i++) begin
            d_drv = f[10-i];
            wait_ticks(HALF);
            c_drv = 1'b0;
            wait_ticks(HALF);
            c_drv = 1'b1;
            if (i == snap_at) begin
                snap_rd   = bus.reading;
                snap_done = bus.done;
            end
        end
        d_drv = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b0;
        repeat (5) @(posedge qzt_clk);
        #1 reset = 1'b0;
        chk("rst_reading", bus.reading, 0);
        chk("rst_done",    bus.done,    0);
        chk("rst_err",     bus.err,     0);
        chk("rst_errcode", bus.errcode, 0);
        chk("rst_data",    bus.data,    0);

        // 0xFA
        bus.enable = 1'b1;
        wait_ticks(20);
        send_bits(mk_frame(8'hFA, 1'b0), 11, 4);
        chk("fa_reading_mid", snap_rd, 1);
        chk("fa_data",    bus.data, 11'h17F);
        chk("fa_done",    bus.done, 1);
        chk("fa_err",     bus.err, 0);
        chk("fa_reading", bus.reading, 0);

        // back-to-back 0x08 then 0x01
        wait_ticks(20);
        send_bits(mk_frame(8'h08, 1'b0), 11, 0);
        chk("b08_data", bus.data, 11'h041);
        chk("b08_done", bus.done, 1);
        wait_ticks(4);
        send_bits(mk_frame(8'h01, 1'b0), 11, 0);
        chk("b01_done_drop", snap_done, 0);
        chk("b01_data", bus.data, 11'h201);
        chk("b01_done", bus.done, 1);

        // timeout after 5 bits; fires 100 ticks after the 5th edge
        wait_ticks(20);
        send_bits(mk_frame(8'h55, 1'b0), 5, 0);
        wait_ticks(80);
        chk("to_err_early",     bus.err, 0);
        chk("to_reading_early", bus.reading, 1);
        wait_ticks(25);
        chk("to_err",     bus.err, 1);
        chk("to_errcode", bus.errcode, 1);
        chk("to_reading", bus.reading, 0);
        chk("to_done",    bus.done, 0);
        chk("to_data",    bus.data, 11'h201);

        // enable low: full frame ignored, state untouched
        wait_ticks(20);
        bus.enable = 1'b0;
        send_bits(mk_frame(8'h3C, 1'b0), 11, 3);
        chk("dis_reading_mid", snap_rd, 0);
        chk("dis_done", bus.done, 0);
        chk("dis_err",  bus.err, 1);
        chk("dis_data", bus.data, 11'h201);
        wait_ticks(20);
        bus.enable = 1'b1;
        wait_ticks(4);
        send_bits(mk_frame(8'h3C, 1'b0), 11, 0);
        chk("en_data",    bus.data, 11'h0F3);
        chk("en_done",    bus.done, 1);
        chk("en_err",     bus.err, 0);
        chk("en_errcode", bus.errcode, 0);

        // bad parity is passed through
        wait_ticks(20);
        send_bits(mk_frame(8'hFA, 1'b1), 11, 0);
        chk("bp_data", bus.data, 11'h17D);
        chk("bp_done", bus.done, 1);
        chk("bp_err",  bus.err, 0);

        // reset mid-frame
        wait_ticks(20);
        send_bits(mk_frame(8'hA5, 1'b0), 4, 0);
        @(posedge qzt_clk);
        #1 reset = 1'b1;
        @(posedge qzt_clk);
        #1 reset = 1'b0;
        chk("mr_reading", bus.reading, 0);
        chk("mr_done",    bus.done, 0);
        chk("mr_err",     bus.err, 0);
        chk("mr_data",    bus.data, 0);
        wait_ticks(20);
        send_bits(mk_frame(8'hA5, 1'b0), 11, 0);
        chk("a5_data", bus.data, 11'h297);
        chk("a5_done", bus.done, 1);
        chk("a5_err",  bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
